// File: rtl/pong_pkg.sv
// Shared Pong types and screen geometry used by the paddle, ball and renderer blocks.
// Pure declarations: no logic, no latency, no flow control.
package pong_pkg;

    typedef enum logic [1:0] {IDLE, RAMP, CRUISE} paddle_state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} paddle_dir_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running divider: one-cycle tick every DIV clk cycles, the first one DIV cycles after reset.
// Tick is decoded from the counter register; there is no backpressure and the counter never stalls.
module pong_tick_gen #(
    parameter int DIV = 32768
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/paddle_ctrl.sv
// Paddle centre-line controller with button/auto tracking, speed ramp and recentre.
// Buttons reach the request 2 clk after the pin; position moves only on ticks; no backpressure.
module paddle_ctrl #(
    parameter int SCREEN_H    = 480,
    parameter int PADDLE_HALF = 20,
    parameter int Y_W         = 10,
    parameter int TICK_DIV    = 32768,
    parameter int MAX_SPEED   = 4,
    parameter int ACCEL_TICKS = 8,
    parameter int DEADBAND    = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           mv_up_n,
    input  logic           mv_down_n,
    input  logic           auto_en,
    input  logic [Y_W-1:0] ball_y,
    input  logic           recenter,
    output logic [Y_W-1:0] y_pos,
    output logic [3:0]     speed,
    output logic           moving,
    output logic           at_top,
    output logic           at_bottom
);

    import pong_pkg::*;

    localparam int AW = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [Y_W:0]   Y_MIN    = (Y_W+1)'(PADDLE_HALF);
    localparam logic [Y_W:0]   Y_MAX    = (Y_W+1)'(SCREEN_H - PADDLE_HALF);
    localparam logic [Y_W-1:0] Y_CTR    = Y_W'(SCREEN_H / 2);
    localparam logic [Y_W:0]   DB       = (Y_W+1)'(DEADBAND);
    localparam logic [3:0]     SPD_MAX  = 4'(MAX_SPEED);
    localparam logic [AW-1:0]  ACC_LAST = AW'(ACCEL_TICKS - 1);

    logic          tick;
    logic [1:0]    up_sync;
    logic [1:0]    dn_sync;
    logic          up_req;
    logic          dn_req;
    paddle_state_t state;
    paddle_state_t nxt_state;
    paddle_dir_t   dir;
    paddle_dir_t   nxt_dir;
    paddle_dir_t   req;
    logic [3:0]    nxt_speed;
    logic [AW-1:0] acc;
    logic [AW-1:0] nxt_acc;
    logic          step_en;
    logic [Y_W:0]  pos_ext;
    logic [Y_W:0]  ball_ext;
    logic [Y_W:0]  step;
    logic [Y_W-1:0] nxt_y;

    pong_tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // Buttons idle high, so the synchronisers reset to the released level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_sync <= 2'b11;
            dn_sync <= 2'b11;
        end else begin
            up_sync <= {up_sync[0], mv_up_n};
            dn_sync <= {dn_sync[0], mv_down_n};
        end
    end

    assign up_req   = ~up_sync[1];
    assign dn_req   = ~dn_sync[1];
    assign pos_ext  = {1'b0, y_pos};
    assign ball_ext = {1'b0, ball_y};

    always_comb begin
        req = DIR_NONE;
        if (auto_en) begin
            if (ball_ext + DB < pos_ext) begin
                req = DIR_UP;
            end else if (ball_ext > pos_ext + DB) begin
                req = DIR_DOWN;
            end
        end else if (up_req && !dn_req) begin
            req = DIR_UP;
        end else if (dn_req && !up_req) begin
            req = DIR_DOWN;
        end
    end

    // speed always reports the step applied on the most recent tick.
    always_comb begin
        nxt_state = state;
        nxt_dir   = dir;
        nxt_speed = speed;
        nxt_acc   = acc;
        step_en   = 1'b0;
        if (req == DIR_NONE) begin
            nxt_state = IDLE;
            nxt_dir   = DIR_NONE;
            nxt_speed = '0;
            nxt_acc   = '0;
        end else if (state == IDLE || req != dir) begin
            nxt_state = (SPD_MAX == 4'd1) ? CRUISE : RAMP;
            nxt_dir   = req;
            nxt_speed = 4'd1;
            nxt_acc   = '0;
            step_en   = 1'b1;
        end else if (state == RAMP) begin
            step_en = 1'b1;
            if (acc == ACC_LAST) begin
                nxt_acc   = '0;
                nxt_speed = speed + 4'd1;
                if (speed + 4'd1 == SPD_MAX) begin
                    nxt_state = CRUISE;
                end
            end else begin
                nxt_acc = acc + 1'b1;
            end
        end else begin
            step_en = 1'b1;
        end
    end

    assign step = {{(Y_W-3){1'b0}}, nxt_speed};

    always_comb begin
        nxt_y = y_pos;
        if (step_en) begin
            if (nxt_dir == DIR_UP) begin
                nxt_y = (pos_ext < Y_MIN + step) ? Y_W'(Y_MIN) : Y_W'(pos_ext - step);
            end else begin
                nxt_y = (pos_ext + step > Y_MAX) ? Y_W'(Y_MAX) : Y_W'(pos_ext + step);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            dir       <= DIR_NONE;
            acc       <= '0;
            y_pos     <= Y_CTR;
            speed     <= '0;
            moving    <= 1'b0;
            at_top    <= 1'b0;
            at_bottom <= 1'b0;
        end else if (recenter) begin
            state     <= IDLE;
            dir       <= DIR_NONE;
            acc       <= '0;
            y_pos     <= Y_CTR;
            speed     <= '0;
            moving    <= 1'b0;
            at_top    <= ({1'b0, Y_CTR} == Y_MIN);
            at_bottom <= ({1'b0, Y_CTR} == Y_MAX);
        end else if (tick) begin
            state     <= nxt_state;
            dir       <= nxt_dir;
            acc       <= nxt_acc;
            y_pos     <= nxt_y;
            speed     <= nxt_speed;
            moving    <= (nxt_state != IDLE);
            at_top    <= ({1'b0, nxt_y} == Y_MIN);
            at_bottom <= ({1'b0, nxt_y} == Y_MAX);
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// Bench for paddle_ctrl: per-cycle reference model plus directed scenarios with literal expectations.
module tb_paddle_ctrl;

    localparam int TD   = 4;
    localparam int PH   = 20;
    localparam int MS   = 4;
    localparam int AT   = 2;
    localparam int DBND = 4;
    localparam int SH   = 480;
    localparam int YW   = 10;
    localparam int YMIN = PH;
    localparam int YMAX = SH - PH;
    localparam int YCTR = SH / 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          mv_up_n = 1'b1;
    logic          mv_down_n = 1'b1;
    logic          auto_en = 1'b0;
    logic [YW-1:0] ball_y = '0;
    logic          recenter = 1'b0;
    logic [YW-1:0] y_pos;
    logic [3:0]    speed;
    logic          moving;
    logic          at_top;
    logic          at_bottom;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    paddle_ctrl #(
        .SCREEN_H(SH), .PADDLE_HALF(PH), .Y_W(YW), .TICK_DIV(TD),
        .MAX_SPEED(MS), .ACCEL_TICKS(AT), .DEADBAND(DBND)
    ) u_dut (
        .clk(clk), .rst(rst), .mv_up_n(mv_up_n), .mv_down_n(mv_down_n),
        .auto_en(auto_en), .ball_y(ball_y), .recenter(recenter),
        .y_pos(y_pos), .speed(speed), .moving(moving),
        .at_top(at_top), .at_bottom(at_bottom)
    );

    always #5 clk = ~clk;

    // Model: a movement run of n same-direction ticks (n from 0) steps min(MS, 1 + n/AT) pixels.
    typedef struct {
        int y;
        int spd;
        int run;
        int dir;
        bit act;
    } mdl_t;

    mdl_t       m;
    int         m_cnt;
    logic [1:0] m_su;
    logic [1:0] m_sd;

    function automatic mdl_t model_step(mdl_t cur, bit tk, bit rc, bit au, int by, bit up, bit dn);
        mdl_t n;
        int   req;
        int   s;
        n   = cur;
        req = 0;
        if (rc) begin
            n.y = YCTR; n.spd = 0; n.run = 0; n.dir = 0; n.act = 1'b0;
            return n;
        end
        if (!tk) return n;
        if (au) begin
            if (by + DBND < cur.y) req = -1;
            else if (by > cur.y + DBND) req = 1;
        end else begin
            if (up && !dn) req = -1;
            else if (dn && !up) req = 1;
        end
        if (req == 0) begin
            n.act = 1'b0; n.spd = 0; n.run = 0; n.dir = 0;
        end else begin
            if (cur.act && req == cur.dir) n.run = cur.run + 1;
            else begin
                n.run = 0;
                n.dir = req;
            end
            n.act = 1'b1;
            s = 1 + n.run / AT;
            n.spd = (s > MS) ? MS : s;
            n.y = cur.y + req * n.spd;
            if (n.y < YMIN) n.y = YMIN;
            if (n.y > YMAX) n.y = YMAX;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m     <= '{y: YCTR, spd: 0, run: 0, dir: 0, act: 1'b0};
            m_cnt <= 0;
            m_su  <= 2'b11;
            m_sd  <= 2'b11;
        end else begin
            m     <= model_step(m, m_cnt == TD - 1, recenter, auto_en, int'(ball_y), !m_su[1], !m_sd[1]);
            m_cnt <= (m_cnt == TD - 1) ? 0 : m_cnt + 1;
            m_su  <= {m_su[0], mv_up_n};
            m_sd  <= {m_sd[0], mv_down_n};
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            chk("cyc_y_pos", int'(y_pos), m.y);
            chk("cyc_speed", int'(speed), m.spd);
            chk("cyc_moving", int'(moving), int'(m.act));
            chk("cyc_at_top", int'(at_top), (m.y == YMIN) ? 1 : 0);
            chk("cyc_at_bottom", int'(at_bottom), (m.y == YMAX) ? 1 : 0);
            chk("cyc_tick", int'(u_dut.tick), (m_cnt == TD - 1) ? 1 : 0);
        end
    end

    task automatic wait_y(input int target, input int budget);
        int n;
        n = 0;
        while (int'(y_pos) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("reach_y", int'(y_pos), target);
    endtask

    task automatic wait_move(input int budget);
        int n;
        int prev;
        n    = 0;
        prev = int'(y_pos);
        do begin
            @(negedge clk);
            n++;
        end while (int'(y_pos) == prev && n < budget);
    endtask

    task automatic pulse_recenter();
        @(negedge clk);
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
    endtask

    int down_exp[8] = '{241, 242, 244, 246, 249, 252, 256, 260};

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_y_pos", int'(y_pos), 240);
        chk("rst_speed", int'(speed), 0);
        chk("rst_moving", int'(moving), 0);
        chk("rst_at_top", int'(at_top), 0);
        chk("rst_at_bottom", int'(at_bottom), 0);
        rst = 1'b0;
        started = 1'b1;

        repeat (40) @(negedge clk);
        chk("idle_y_pos", int'(y_pos), 240);
        chk("idle_moving", int'(moving), 0);

        // Down ramp, then recentre on a tick that would otherwise move to 304.
        mv_down_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wait_move(20);
            chk("down_seq", int'(y_pos), down_exp[i]);
        end
        chk("cruise_speed", int'(speed), 4);
        wait_y(300, 100);
        n = 0;
        while (m_cnt != TD - 1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        recenter = 1'b1;
        @(negedge clk);
        recenter = 1'b0;
        chk("recenter_y", int'(y_pos), 240);
        chk("recenter_speed", int'(speed), 0);

        // Saturate at the bottom, then reverse.
        wait_y(460, 400);
        repeat (16) @(negedge clk);
        chk("bottom_y", int'(y_pos), 460);
        chk("bottom_flag", int'(at_bottom), 1);
        chk("bottom_moving", int'(moving), 1);
        mv_down_n = 1'b1;
        mv_up_n   = 1'b0;
        wait_move(20);
        chk("reverse_y", int'(y_pos), 459);
        chk("reverse_speed", int'(speed), 1);
        chk("reverse_at_bottom", int'(at_bottom), 0);

        // Both buttons held cancel each other.
        mv_up_n = 1'b1;
        repeat (8) @(negedge clk);
        pulse_recenter();
        mv_up_n   = 1'b0;
        mv_down_n = 1'b0;
        repeat (24) @(negedge clk);
        chk("both_y", int'(y_pos), 240);
        chk("both_moving", int'(moving), 0);
        chk("both_speed", int'(speed), 0);
        mv_up_n = 1'b1;

        // Asynchronous reset in cruise, then first tick TD cycles after release.
        wait_y(300, 200);
        chk("pre_rst_speed", int'(speed), 4);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_y", int'(y_pos), 240);
        chk("async_rst_speed", int'(speed), 0);
        chk("async_rst_moving", int'(moving), 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        while (int'(y_pos) == 240 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("first_tick_latency", n, 4);
        chk("first_tick_y", int'(y_pos), 241);
        mv_down_n = 1'b1;

        // Auto tracking.
        repeat (8) @(negedge clk);
        pulse_recenter();
        auto_en = 1'b1;
        ball_y  = 10'd100;
        wait_y(104, 400);
        repeat (12) @(negedge clk);
        chk("auto1_y", int'(y_pos), 104);
        chk("auto1_moving", int'(moving), 0);
        ball_y = 10'd20;
        repeat (200) @(negedge clk);
        chk("auto2_y", int'(y_pos), 24);
        chk("auto2_moving", int'(moving), 0);
        ball_y = 10'd0;
        wait_y(20, 100);
        repeat (12) @(negedge clk);
        chk("auto_top_y", int'(y_pos), 20);
        chk("auto_top_flag", int'(at_top), 1);
        chk("auto_top_moving", int'(moving), 1);
        auto_en = 1'b0;

        @(negedge clk);
        started = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
        $fatal(1);
    end

endmodule
